// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bundle: redirect/stall inputs toward the sequencer and the
// instruction-memory request it drives.
interface fetch_ctrl_if;
  localparam int unsigned XLEN = 32;

  logic            stall;
  logic            branch_taken;
  logic [XLEN-1:0] alu_out;
  logic            trap_req;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] pc_plus4;
  logic            fetch_kill;

  // The sequencer is the request master toward instruction memory.
  modport master (
    input  stall, branch_taken, alu_out, trap_req, imem_req_ready,
    output imem_req_valid, imem_addr, pc_out, pc_plus4, fetch_kill
  );

  modport slave (
    output stall, branch_taken, alu_out, trap_req, imem_req_ready,
    input  imem_req_valid, imem_addr, pc_out, pc_plus4, fetch_kill
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage PC sequencer: owns the PC and the imem request handshake,
// arbitrating sequential advance, branch/trap redirects and hazard stalls.
module fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic clk,
  input  logic rst,
  fetch_ctrl_if.master bus
);
  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            pend_valid_q, pend_valid_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;

  logic            redir;
  logic [XLEN-1:0] target;
  logic            req_valid;
  logic            hs;
  logic [XLEN-1:0] pc_plus4;

  // Redirect decode; trap outranks branch, branch targets are word aligned.
  always_comb begin
    redir  = bus.trap_req | bus.branch_taken;
    target = bus.trap_req ? TRAP_VECTOR : (bus.alu_out & ~XLEN'(32'h3));
  end

  // A request, once raised in WAIT, is held until accepted.
  always_comb begin
    req_valid = 1'b0;
    case (state_q)
      ST_RUN:  req_valid = ~bus.stall;
      ST_WAIT: req_valid = 1'b1;
      default: req_valid = 1'b0;
    endcase
  end

  assign hs       = req_valid & bus.imem_req_ready;
  assign pc_plus4 = pc_q + XLEN'(4);

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_addr      = pc_q;
  assign bus.pc_out         = pc_q;
  assign bus.pc_plus4       = pc_plus4;
  assign bus.fetch_kill     = hs & (redir | pend_valid_q);

  // Next-state: PC selection and pending-redirect bookkeeping.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;

    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end

      ST_RUN: begin
        if (req_valid) begin
          if (bus.imem_req_ready) begin
            pc_d = redir ? target : pc_plus4;
          end else begin
            state_d = ST_WAIT;
            if (redir) begin
              pend_valid_d = 1'b1;
              pend_pc_d    = target;
            end
          end
        end else if (redir) begin
          pc_d = target;
        end
      end

      ST_WAIT: begin
        if (bus.imem_req_ready) begin
          if (redir)             pc_d = target;
          else if (pend_valid_q) pc_d = pend_pc_q;
          else                   pc_d = pc_plus4;
          pend_valid_d = 1'b0;
          state_d      = ST_RUN;
        end else if (redir) begin
          // Newest redirect wins over any older pending one.
          pend_valid_d = 1'b1;
          pend_pc_d    = target;
        end
      end

      default: begin
        state_d      = ST_BOOT;
        pc_d         = RESET_VECTOR;
        pend_valid_d = 1'b0;
        pend_pc_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_VECTOR;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
    end
  end

  // An unaccepted request stays up with a stable address.
  a_req_hold : assert property (
    @(posedge clk) disable iff (!rst)
    (req_valid && !bus.imem_req_ready) |=> (req_valid && $stable(pc_q))
  );

  // A pending redirect only exists while a request is outstanding.
  a_pend_only_in_wait : assert property (
    @(posedge clk) disable iff (!rst)
    pend_valid_q |-> (state_q == ST_WAIT)
  );
endmodule
